// File: rtl/fixed_point_multiplier.sv
// -----------------------------------------------------------------------------
// fixed_point_multiplier
//
// Sequential signed Qm.n fixed-point multiplier: oResult = (iA * iB) >> SCALE.
// The operands' magnitudes are multiplied with an iterative shift-add, one
// multiplier bit per cycle. Latency is fixed and does not depend on the data.
// The truncated magnitude is then sign-applied and saturated to WIDTH bits.
// The handshake matches the fixed-point divider, so either unit can be driven
// by the same client FSM.
//
// Ports
//   Clock        : clock; all state updates on the rising edge
//   Reset        : synchronous, active-high reset (aborts any operation)
//   iA, iB       : signed Qm.n multiplicand / multiplier
//   iInputReady  : request; operands are valid while high. The client holds it
//                  high until it has read the result.
//   oResult      : signed Qm.n product (saturated)
//   OutputReady  : result valid; held until the request is dropped
//   oOverflow    : result saturated; valid while OutputReady is high
//
// Timing: a request sampled at edge 0 updates oResult/OutputReady at edge
// WIDTH+1. There are WIDTH multiply steps, followed by one normalize step.
// -----------------------------------------------------------------------------
module fixed_point_multiplier #(
  parameter int WIDTH = 32,
  parameter int SCALE = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iInputReady,
  output logic [WIDTH-1:0] oResult,
  output logic             OutputReady,
  output logic             oOverflow
);

  localparam int CW = $clog2(WIDTH + 1);

  // Largest positive magnitude and largest negative magnitude, widened to
  // the accumulator width for comparison.
  localparam logic [2*WIDTH-1:0] MAX_POS_MAG = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MAX_NEG_MAG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MULTIPLY,
    NORMALIZE,
    DONE
  } state_t;

  state_t stateReg, stateNext;

  logic                 signReg;
  logic [2*WIDTH-1:0]   mcandReg;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]     mplierReg;  // multiplier, shifted right each step
  logic [2*WIDTH-1:0]   accReg;
  logic [CW-1:0]        countReg;

  // Magnitudes of the operands. Negating the most negative value gives
  // 2^(WIDTH-1), which is still correct when the bits are read as unsigned.
  logic [WIDTH-1:0]   absA, absB;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] magnitude;
  logic [WIDTH-1:0]   magLow;
  logic               lastStep;
  logic               satPos, satNeg;
  logic [WIDTH-1:0]   normResult;

  always_comb begin
    absA      = iA[WIDTH-1] ? (~iA + WIDTH'(1)) : iA;
    absB      = iB[WIDTH-1] ? (~iB + WIDTH'(1)) : iB;
    addend    = mplierReg[0] ? mcandReg : '0;
    lastStep  = (countReg == CW'(WIDTH - 1));

    // Shifting the magnitude, not the signed value, truncates toward zero.
    magnitude = accReg >> SCALE;
    magLow    = magnitude[WIDTH-1:0];
    satPos    = !signReg && (magnitude > MAX_POS_MAG);
    satNeg    =  signReg && (magnitude > MAX_NEG_MAG);

    if (satPos) begin
      normResult = SAT_POS;
    end else if (satNeg) begin
      normResult = SAT_NEG;
    end else if (signReg) begin
      normResult = ~magLow + WIDTH'(1);  // negating zero gives zero
    end else begin
      normResult = magLow;
    end
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:      if (iInputReady) stateNext = MULTIPLY;
      MULTIPLY:  if (lastStep)    stateNext = NORMALIZE;
      NORMALIZE:                  stateNext = DONE;
      DONE:      if (!iInputReady) stateNext = IDLE;
      default:                    stateNext = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      signReg     <= 1'b0;
      mcandReg    <= '0;
      mplierReg   <= '0;
      accReg      <= '0;
      countReg    <= '0;
      oResult     <= '0;
      OutputReady <= 1'b0;
      oOverflow   <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          OutputReady <= 1'b0;
          if (iInputReady) begin
            signReg   <= iA[WIDTH-1] ^ iB[WIDTH-1];
            mcandReg  <= {{WIDTH{1'b0}}, absA};
            mplierReg <= absB;
            accReg    <= '0;
            countReg  <= '0;
          end
        end
        MULTIPLY: begin
          accReg    <= accReg + addend;
          mcandReg  <= mcandReg << 1;
          mplierReg <= mplierReg >> 1;
          countReg  <= countReg + CW'(1);
        end
        NORMALIZE: begin
          oResult     <= normResult;
          oOverflow   <= satPos || satNeg;
          OutputReady <= 1'b1;
        end
        DONE: begin
          // Result is held until the client drops the request; operand
          // changes are ignored.
          if (!iInputReady) begin
            OutputReady <= 1'b0;
          end
        end
        default: begin
          OutputReady <= 1'b0;
        end
      endcase
    end
  end

endmodule
